alu_operand_stage: RTL

- Decode/operand-fetch stage directly upstream of the 8-bit ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them to the ALU's ctrl/flag encoding.
- Reads an internal 8x8 register file, with bypass from the writeback port.
- Issues registered a/b/ctrl/flag operands one cycle later. A per-register scoreboard stalls instructions whose sources or destination are still in flight.

---
 rtl/alu_operand_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage feeding the 8-bit ALU: decodes 16-bit instructions,
// reads the register file with writeback bypass, and stalls on scoreboard hazards.
module alu_operand_stage #(
    parameter int DATA_W = 8,
    parameter bit SB_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    output logic              in_ready,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_ctrl,
    output logic              out_flag,
    output logic [2:0]        out_rd,
    output logic              out_we,
    output logic              out_illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        ctrl;
        logic              flag;
        logic [2:0]        rd;
        logic              we;
        logic              illegal;
    } bundle_t;

    logic [3:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [5:0]        imm6;
    logic              is_rtype;
    logic              is_illegal;

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [7:0]        pending_q;
    logic [7:0]        pending_d;
    logic [7:0]        wb_clr;
    logic [7:0]        pend_eff;
    logic              out_valid_q;
    logic              out_valid_d;
    bundle_t           bundle_q;
    bundle_t           bundle_d;

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm_ext;
    logic [2:0]        ctrl;
    logic              flag;
    logic              hazard;
    logic              accept;

    assign opcode     = in_instr[15:12];
    assign rd         = in_instr[11:9];
    assign rs1        = in_instr[8:6];
    assign rs2        = in_instr[5:3];
    assign imm6       = in_instr[5:0];
    assign is_rtype   = ~opcode[3];
    assign is_illegal = &opcode[3:2];
    assign imm_ext    = {{(DATA_W-6){imm6[5]}}, imm6};

    // A pending bit being retired by writeback this cycle no longer blocks issue.
    assign wb_clr   = wb_en ? (8'd1 << wb_addr) : 8'd0;
    assign pend_eff = pending_q & ~wb_clr;
    assign hazard   = SB_EN && (pend_eff[rs1] || (is_rtype && pend_eff[rs2]) || pend_eff[rd]);
    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        rs1_val = regs_q[rs1];
        if (wb_en && wb_addr == rs1) rs1_val = wb_data;
        if (rs1 == 3'd0) rs1_val = '0;
        rs2_val = regs_q[rs2];
        if (wb_en && wb_addr == rs2) rs2_val = wb_data;
        if (rs2 == 3'd0) rs2_val = '0;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        {ctrl, flag} = 4'b0000;
        case (opcode)
            4'h1:       {ctrl, flag} = 4'b0001;
            4'h2:       {ctrl, flag} = 4'b0010;
            4'h3:       {ctrl, flag} = 4'b0011;
            4'h4:       {ctrl, flag} = 4'b0100;
            4'h5, 4'h9: {ctrl, flag} = 4'b0110;
            4'h6, 4'hA: {ctrl, flag} = 4'b0111;
            4'h7, 4'hB: {ctrl, flag} = 4'b1000;
            default:    {ctrl, flag} = 4'b0000;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_addr != 3'd0) regs_d[wb_addr] = wb_data;
    end

    always_comb begin
        pending_d = pending_q & ~wb_clr;
        if (accept && !is_illegal && rd != 3'd0) pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            bundle_d.rd = rd;
            if (is_illegal) begin
                bundle_d.a       = '0;
                bundle_d.b       = '0;
                bundle_d.ctrl    = 3'd0;
                bundle_d.flag    = 1'b0;
                bundle_d.we      = 1'b0;
                bundle_d.illegal = 1'b1;
            end else begin
                bundle_d.a       = rs1_val;
                bundle_d.b       = is_rtype ? rs2_val : imm_ext;
                bundle_d.ctrl    = ctrl;
                bundle_d.flag    = flag;
                bundle_d.we      = (rd != 3'd0);
                bundle_d.illegal = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: the register file is reset too, since architectural registers must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            regs_q <= regs_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_a       = bundle_q.a;
    assign out_b       = bundle_q.b;
    assign out_ctrl    = bundle_q.ctrl;
    assign out_flag    = bundle_q.flag;
    assign out_rd      = bundle_q.rd;
    assign out_we      = bundle_q.we;
    assign out_illegal = bundle_q.illegal;

endmodule
